// File: rtl/date_pkg.sv
// Shared types and month-length constants for the date_to_doy encoder.
// DATE_LEAP_YEAR_EN selects a 29-day February.
package date_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM, DONE} state_t;

  localparam logic [3:0] MONTHS     = 4'd12;
  localparam logic [4:0] LONG_DAYS  = 5'd31;
  localparam logic [4:0] SHORT_DAYS = 5'd30;
`ifdef DATE_LEAP_YEAR_EN
  localparam logic [4:0] FEB_DAYS   = 5'd29;
`else
  localparam logic [4:0] FEB_DAYS   = 5'd28;
`endif

endpackage

// File: rtl/date_to_doy_if.sv
// Request/result bundle between the entry logic and the day-of-year encoder.
interface date_to_doy_if;
  logic       start;
  logic [3:0] month;
  logic [4:0] day;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] doy;

  modport master (output start, month, day, input busy, done, err, doy);
  modport slave  (input start, month, day, output busy, done, err, doy);
endinterface

// File: rtl/month_len_rom.sv
// Combinational month-length lookup; months outside 1..12 report 0 days.
module month_len_rom
  import date_pkg::*;
(
  input  logic [3:0] month,
  output logic [4:0] days
);

  always_comb begin
    days = 5'd0;
    case (month)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days = LONG_DAYS;
      4'd4, 4'd6, 4'd9, 4'd11:                    days = SHORT_DAYS;
      4'd2:                                       days = FEB_DAYS;
      default:                                    days = 5'd0;
    endcase
  end

endmodule

// File: rtl/date_to_doy.sv
// Sequential month/day to day-of-year encoder: walks one month per clock.
// February length follows DATE_LEAP_YEAR_EN (see date_pkg).
module date_to_doy
  import date_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  date_to_doy_if.slave bus
);

  state_t     state_q, state_d;
  logic [3:0] m_req_q, m_req_d;
  logic [4:0] d_req_q, d_req_d;
  logic [3:0] m_cnt_q, m_cnt_d;
  logic [8:0] acc_q, acc_d;
  logic [8:0] doy_q, doy_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic [4:0] chk_len, acc_len;

  month_len_rom u_chk_rom (.month(m_req_q), .days(chk_len));
  month_len_rom u_acc_rom (.month(m_cnt_q), .days(acc_len));

  // Result registers load on the edge entering DONE so doy/err/done
  // are all visible during the DONE cycle itself.
  always_comb begin
    state_d = state_q;
    m_req_d = m_req_q;
    d_req_d = d_req_q;
    m_cnt_d = m_cnt_q;
    acc_d   = acc_q;
    doy_d   = doy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_req_d = bus.month;
          d_req_d = bus.day;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (m_req_q == 4'd0 || m_req_q > MONTHS ||
            d_req_q == 5'd0 || d_req_q > chk_len) begin
          acc_d   = 9'd0;
          doy_d   = 9'd0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          acc_d   = {4'd0, d_req_q};
          m_cnt_d = 4'd1;
          if (m_req_q > 4'd1) begin
            state_d = ACCUM;
          end else begin
            doy_d   = {4'd0, d_req_q};
            err_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        acc_d   = acc_q + {4'd0, acc_len};
        m_cnt_d = m_cnt_q + 4'd1;
        if (m_cnt_d == m_req_q) begin
          doy_d   = acc_d;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_req_q <= 4'd0;
      d_req_q <= 5'd0;
      m_cnt_q <= 4'd0;
      acc_q   <= 9'd0;
      doy_q   <= 9'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_req_q <= m_req_d;
      d_req_q <= d_req_d;
      m_cnt_q <= m_cnt_d;
      acc_q   <= acc_d;
      doy_q   <= doy_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.doy  = doy_q;

endmodule

// File: tb/tb_date_to_doy.sv
// Self-checking bench for date_to_doy: calendar reference model, directed
// cases and randomized requests with stray starts and resets.
module tb_date_to_doy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  date_to_doy_if bus ();

  date_to_doy dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

`ifdef DATE_LEAP_YEAR_EN
  localparam int FEB = 29, D_MAR1 = 61, D_DEC31 = 366, D_JUN15 = 167;
  localparam int F29_LAT = 3, F29_DOY = 60, F29_ERR = 0;
`else
  localparam int FEB = 28, D_MAR1 = 60, D_DEC31 = 365, D_JUN15 = 166;
  localparam int F29_LAT = 2, F29_DOY = 0, F29_ERR = 1;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int mlen(input int m);
    int t[12] = '{31, FEB, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    return t[m-1];
  endfunction

  function automatic bit ref_ok(input int m, input int d);
    return (m >= 1 && m <= 12 && d >= 1 && d <= mlen(m));
  endfunction

  function automatic int ref_doy(input int m, input int d);
    int s;
    if (!ref_ok(m, d)) return 0;
    s = d;
    for (int i = 1; i < m; i++) s += mlen(i);
    return s;
  endfunction

  // Reference: a request is a timed job; busy until done, result at the end.
  bit   active;
  int   rem;
  logic busy_e, done_e, err_e;
  int   doy_e, p_doy;
  logic p_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active = 0; rem = 0; busy_e = 0; done_e = 0; err_e = 0; doy_e = 0;
    end else if (!active) begin
      done_e = 0;
      if (bus.start) begin
        active = 1;
        busy_e = 1;
        p_err  = !ref_ok(int'(bus.month), int'(bus.day));
        p_doy  = ref_doy(int'(bus.month), int'(bus.day));
        rem    = p_err ? 1 : int'(bus.month);
      end
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        done_e = 1; doy_e = p_doy; err_e = p_err;
      end
    end else begin
      active = 0; busy_e = 0; done_e = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", int'(bus.busy), int'(busy_e));
      chk("done", int'(bus.done), int'(done_e));
      chk("err",  int'(bus.err),  int'(err_e));
      chk("doy",  int'(bus.doy),  doy_e);
    end
  end

  // Called on a negedge; returns the cycle number (1 = cycle after the
  // sampling edge) on which done was observed.
  task automatic req(input int m, input int d, output int n);
    bus.start = 1'b1; bus.month = 4'(m); bus.day = 5'(d);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("req_timeout", 0, 1);
  endtask

  int cm[7] = '{1, 3, 12, 2, 13, 4, 0};
  int cd[7] = '{1, 1, 31, 29, 5, 31, 0};
  int cl[7] = '{2, 4, 13, F29_LAT, 2, 2, 2};
  int cy[7] = '{1, D_MAR1, D_DEC31, F29_DOY, 0, 0, 0};
  int ce[7] = '{0, 0, 0, F29_ERR, 1, 1, 1};

  initial begin
    int n, ndone, spur;
    bus.start = 1'b0; bus.month = 4'd0; bus.day = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err",  int'(bus.err),  0);
    chk("rst_doy",  int'(bus.doy),  0);
    rst = 1'b0;

    chk("model_mar1",  ref_doy(3, 1),   D_MAR1);
    chk("model_dec31", ref_doy(12, 31), D_DEC31);
    chk("model_jun15", ref_doy(6, 15),  D_JUN15);
    chk("model_feb10", ref_doy(2, 10),  41);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req(cm[i], cd[i], n);
      chk($sformatf("lat_m%0d_d%0d", cm[i], cd[i]), n, cl[i]);
      chk($sformatf("doy_m%0d_d%0d", cm[i], cd[i]), int'(bus.doy), cy[i]);
      chk($sformatf("err_m%0d_d%0d", cm[i], cd[i]), int'(bus.err), ce[i]);
    end

    // June request with an ignored start mid-flight, then a back-to-back one
    @(negedge clk);
    bus.start = 1'b1; bus.month = 4'd6; bus.day = 5'd15;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (ndone == 0) begin
          chk("ovl_first_cyc", c, 7);
          chk("ovl_first_doy", int'(bus.doy), D_JUN15);
        end else if (ndone == 1) begin
          chk("ovl_second_cyc", c, 10);
          chk("ovl_second_doy", int'(bus.doy), 1);
        end
        ndone++;
      end
      bus.start = (c == 3 || c == 8);
      if (c == 3 || c == 8) begin bus.month = 4'd1; bus.day = 5'd1; end
    end
    chk("ovl_done_count", ndone, 2);

    // Reset in the middle of an October conversion
    @(negedge clk);
    bus.start = 1'b1; bus.month = 4'd10; bus.day = 5'd20;
    spur = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) spur++;
    end
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_err",  int'(bus.err),  0);
    chk("arst_doy",  int'(bus.doy),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) spur++;
    end
    chk("arst_no_done", spur, 0);
    req(2, 10, n);
    chk("post_rst_lat", n, 3);
    chk("post_rst_doy", int'(bus.doy), 41);

    // Randomized traffic, including stray starts and occasional resets
    ndone = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      rst       = ($urandom % 600 == 0);
      bus.start = ($urandom % 3 == 0);
      bus.month = ($urandom % 6 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 12));
      bus.day   = ($urandom % 6 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
    end
    rst = 1'b0; bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("rand_activity", int'(ndone > 50), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
